// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: per-pin OUT/OE, synchronised and optionally
// debounced inputs, rise/fall edge capture with sticky maskable status.
// Ports: i_clk, i_rst (async, high); Wishbone slave i_wb_* / o_wb_rdt,
// o_wb_ack; pads i_gpio in, o_gpio / o_gpio_oe out; o_irq level.
`timescale 1ns/1ps
module wb_gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DBW         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  logic             ack_q;
  logic [31:0]      rdt_q, rdt_d, rd_mux;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [DBW-1:0]   db_q, db_d;
  logic [DBW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] prev_q;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic             req, wr, db_wr, tick;
  logic [31:0]      wm;
  logic [WIDTH-1:0] wm_w, wd_w, clr, set, same;
  logic [DBW-1:0]   wm_d;
  logic [WIDTH-1:0] sync;

  // Dead bits of the bus when WIDTH or DBW are narrower than 32.
  logic unused_bits;
  assign unused_bits = ^{i_wb_dat, wm};

  // ack_q blocks a new request so acks can never be back-to-back.
  assign req   = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr    = req & i_wb_we;
  assign db_wr = wr && (i_wb_adr == 3'd7);

  assign wm   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                 {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign wm_w = wm[WIDTH-1:0];
  assign wd_w = i_wb_dat[WIDTH-1:0];
  assign wm_d = wm[DBW-1:0];

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    en_d   = en_q;
    rise_d = rise_q;
    fall_d = fall_q;
    db_d   = db_q;
    clr    = '0;
    if (wr) begin
      case (i_wb_adr)
        3'd1: out_d  = (out_q  & ~wm_w) | (wd_w & wm_w);
        3'd2: oe_d   = (oe_q   & ~wm_w) | (wd_w & wm_w);
        3'd3: en_d   = (en_q   & ~wm_w) | (wd_w & wm_w);
        3'd4: rise_d = (rise_q & ~wm_w) | (wd_w & wm_w);
        3'd5: fall_d = (fall_q & ~wm_w) | (wd_w & wm_w);
        3'd6: clr    = wd_w & wm_w;
        3'd7: db_d   = (db_q & ~wm_d) | (i_wb_dat[DBW-1:0] & wm_d);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_wb_adr)
      3'd0: rd_mux[WIDTH-1:0] = deb_q;
      3'd1: rd_mux[WIDTH-1:0] = out_q;
      3'd2: rd_mux[WIDTH-1:0] = oe_q;
      3'd3: rd_mux[WIDTH-1:0] = en_q;
      3'd4: rd_mux[WIDTH-1:0] = rise_q;
      3'd5: rd_mux[WIDTH-1:0] = fall_q;
      3'd6: rd_mux[WIDTH-1:0] = stat_q;
      3'd7: rd_mux[DBW-1:0]   = db_q;
      default: ;
    endcase
    rdt_d = (req & ~i_wb_we) ? rd_mux : '0;
  end

  // Debounce: a bit is accepted only when two consecutive ticks agree.
  assign tick = (db_q != '0) && (cnt_q == db_q);
  assign same = ~(sync ^ last_q);

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    deb_d  = deb_q;
    if (db_q == '0) begin
      deb_d = sync;
      cnt_d = '0;
    end else if (tick) begin
      deb_d  = (deb_q & ~same) | (sync & same);
      last_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + DBW'(1);
    end
    if (db_wr) begin
      cnt_d  = '0;
      last_d = sync;
    end
  end

  // Set is OR-ed after the clear so a same-cycle edge wins.
  assign set    = (deb_q & ~prev_q & rise_q) | (~deb_q & prev_q & fall_q);
  assign stat_d = (stat_q & ~clr) | set;
  assign irq_d  = |(stat_q & en_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q  <= 1'b0;
      rdt_q  <= '0;
      out_q  <= '0;
      oe_q   <= '0;
      en_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      deb_q  <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      ack_q  <= req;
      rdt_q  <= rdt_d;
      out_q  <= out_d;
      oe_q   <= oe_d;
      en_q   <= en_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      stat_q <= stat_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      deb_q  <= deb_d;
      prev_q <= deb_q;
      irq_q  <= irq_d;
      sync_q[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_rdt  = rdt_q;
  assign o_gpio    = out_q;
  assign o_gpio_oe = oe_q;
  assign o_irq     = irq_q;

endmodule
